inst_encoder: RTL and testbench

- Encoder counterpart of the core's instruction decoder: turns decoded-form operation requests (alu_control code, register numbers, immediate) into 32-bit RV32I R-type (opcode 0x33) and I-type (opcode 0x13) words.
- Words are buffered in a small FIFO and streamed out with sequential instruction addresses.
- Used by the instruction-memory loader and the self-test program generator.

---
 rtl/inst_encoder.sv | 170 +++++++++++++++++
 tb/tb_inst_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I R/I-type instruction encoder with an output FIFO and address tagging.
// Optional INST_ENC_NOP_FILL_EN: illegal requests enqueue a NOP instead of being dropped.
module inst_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [3:0]                 req_alu,
  input  logic                       req_use_imm,
  input  logic [4:0]                 req_rd,
  input  logic [4:0]                 req_rs1,
  input  logic [4:0]                 req_rs2,
  input  logic [31:0]                req_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_addr,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   addr_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;

  logic [2:0]    f3;
  logic [6:0]    f7;
  logic [11:0]   field;
  logic          legal;
  logic          imm_ok;
  logic          sh_ok;
  logic [31:0]   word;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   push_word;

  always_comb begin
    f3     = 3'd0;
    f7     = 7'd0;
    field  = req_imm[11:0];
    legal  = 1'b1;
    imm_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    sh_ok  = ~(|req_imm[31:5]);
    word   = NOP;
    if (!req_use_imm) begin
      unique case (req_alu)
        4'b0010: f3 = 3'd0;
        4'b0100: f7 = 7'h20;
        4'b0001: f3 = 3'd1;
        4'b0101: f3 = 3'd2;
        4'b0111: f3 = 3'd3;
        4'b0110: f3 = 3'd4;
        default: legal = 1'b0;
      endcase
      word = {f7, req_rs2, req_rs1, f3, req_rd, 7'h33};
    end else begin
      unique case (req_alu)
        4'b0010: legal = imm_ok;
        4'b0001: begin
          f3    = 3'd1;
          legal = sh_ok;
          field = {7'b0, req_imm[4:0]};
        end
        4'b0101: begin
          f3    = 3'd2;
          legal = imm_ok;
        end
        4'b0111: begin
          f3    = 3'd3;
          legal = imm_ok;
        end
        default: legal = 1'b0;
      endcase
      word = {field, req_rs1, f3, req_rd, 7'h13};
    end
  end

  assign req_ready = (cnt_q < FULL);
  assign out_valid = (cnt_q != '0);
  assign accept    = req_valid && req_ready && !clear;
  assign pop       = out_valid && out_ready && !clear;

`ifdef INST_ENC_NOP_FILL_EN
  assign push      = accept;
  assign push_word = legal ? word : NOP;
`else
  assign push      = accept && legal;
  assign push_word = word;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    err_d    = err_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      addr_d   = BASE_ADDR;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        addr_d   = addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (accept && !legal) begin
        err_d = 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Word and address are stored side by side so the tag follows the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= push_word;
      addr_mem_q[wr_ptr_q] <= addr_q;
    end
  end

  assign out_inst = out_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign out_addr = out_valid ? addr_mem_q[rd_ptr_q] : addr_q;
  assign err      = err_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed words and addresses.
module tb_inst_encoder;

  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_alu = 4'd0;
  logic        req_use_imm = 1'b0;
  logic [4:0]  req_rd = 5'd0;
  logic [4:0]  req_rs1 = 5'd0;
  logic [4:0]  req_rs2 = 5'd0;
  logic [31:0] req_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  ent_t        mq[$];
  ent_t        cap[$];
  logic [31:0] nxt = BASE;
  bit          merr = 1'b0;

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu(req_alu), .req_use_imm(req_use_imm),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference encoding straight from the opcode tables.
  function automatic bit menc(input logic [3:0] alu, input logic ui,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              output logic [31:0] w);
    logic [31:0] f3, f7, fld;
    longint si;
    f3 = 0; f7 = 0; fld = 0; w = 0;
    si = longint'($signed(imm));
    if (!ui) begin
      case (alu)
        4'd2: f3 = 0;
        4'd4: f7 = 32;
        4'd1: f3 = 1;
        4'd5: f3 = 2;
        4'd7: f3 = 3;
        4'd6: f3 = 4;
        default: return 1'b0;
      endcase
      w = f7 * 32'h0200_0000 + rs2 * 32'h0010_0000 + rs1 * 32'h8000
        + f3 * 32'h1000 + rd * 32'h80 + 32'h33;
      return 1'b1;
    end
    case (alu)
      4'd2: f3 = 0;
      4'd1: f3 = 1;
      4'd5: f3 = 2;
      4'd7: f3 = 3;
      default: return 1'b0;
    endcase
    if (alu == 4'd1) begin
      if (imm > 32'd31) return 1'b0;
      fld = imm;
    end else begin
      if (si < -2048 || si > 2047) return 1'b0;
      fld = imm & 32'hFFF;
    end
    w = fld * 32'h0010_0000 + rs1 * 32'h8000 + f3 * 32'h1000
      + rd * 32'h80 + 32'h13;
    return 1'b1;
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    nxt  = BASE;
    merr = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      logic [31:0] w;
      bit acc, pp, ok;
      if (clear) begin
        mq.delete();
        nxt  = BASE;
        merr = 1'b0;
      end else begin
        acc = req_valid && (mq.size() < DEPTH);
        pp  = (mq.size() != 0) && out_ready;
        if (pp) begin
          cap.push_back(mq[0]);
          void'(mq.pop_front());
        end
        if (acc) begin
          ok = menc(req_alu, req_use_imm, req_rd, req_rs1, req_rs2, req_imm, w);
          if (ok) begin
            mq.push_back('{w, nxt});
            nxt = nxt + 32'd4;
          end else begin
            merr = 1'b1;
`ifdef INST_ENC_NOP_FILL_EN
            mq.push_back('{32'h13, nxt});
            nxt = nxt + 32'd4;
`endif
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", 32'(req_ready), 32'(mq.size() < DEPTH));
    chk("valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("count", 32'(count), 32'(mq.size()));
    chk("err", 32'(err), 32'(merr));
    if (mq.size() != 0) begin
      chk("inst", out_inst, mq[0].inst);
      chk("addr", out_addr, mq[0].addr);
    end else if (!rst_n) begin
      chk("rst_inst", out_inst, 32'd0);
      chk("rst_addr", out_addr, BASE);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [3:0] alu, input logic ui,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    bit done;
    req_alu = alu; req_use_imm = ui; req_rd = rd;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      done = req_ready;
      cyc(1);
      n++;
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic clr();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cap.delete();
  endtask

  initial begin
    logic [31:0] w;
    int nb;
    void'(menc(4'd2, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, w));
    chk("model_add", w, 32'h002081B3);
    void'(menc(4'd4, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0, w));
    chk("model_sub", w, 32'h407302B3);
    void'(menc(4'd2, 1'b1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, w));
    chk("model_addi", w, 32'hFFF00093);
    chk("model_bad", 32'(menc(4'd1, 1'b1, 5'd2, 5'd2, 5'd0, 32'd32, w)), 32'd0);

    cyc(3);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // add x3,x1,x2 visible the edge after acceptance
    out_ready = 1'b1;
    send(4'd2, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    #3;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_inst", out_inst, 32'h002081B3);
    chk("add_addr", out_addr, 32'h0);
    chk("add_err", 32'(err), 32'd0);
    cyc(2);

    clr();
    send(4'd4, 1'b0, 5'd5, 5'd6, 5'd7, 32'd0);
    send(4'd2, 1'b1, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    cyc(3);
    chk("sub_n", 32'(cap.size()), 32'd2);
    if (cap.size() == 2) begin
      chk("sub_inst", cap[0].inst, 32'h407302B3);
      chk("sub_addr", cap[0].addr, 32'h0);
      chk("addi_inst", cap[1].inst, 32'hFFF00093);
      chk("addi_addr", cap[1].addr, 32'h4);
    end

    // slli legal, then out-of-range shift
    clr();
    send(4'd1, 1'b1, 5'd2, 5'd2, 5'd0, 32'd5);
    send(4'd1, 1'b1, 5'd2, 5'd2, 5'd0, 32'd32);
    #3;
    chk("slli_err", 32'(err), 32'd1);
    cyc(1);
    send(4'd2, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    cyc(3);
`ifdef INST_ENC_NOP_FILL_EN
    chk("slli_n", 32'(cap.size()), 32'd3);
    if (cap.size() == 3) begin
      chk("slli_inst", cap[0].inst, 32'h00511113);
      chk("nop_inst", cap[1].inst, 32'h00000013);
      chk("nop_addr", cap[1].addr, 32'h4);
      chk("after_addr", cap[2].addr, 32'h8);
    end
`else
    chk("slli_n", 32'(cap.size()), 32'd2);
    if (cap.size() == 2) begin
      chk("slli_inst", cap[0].inst, 32'h00511113);
      chk("after_addr", cap[1].addr, 32'h4);
    end
`endif

    // immediate range boundaries and illegal combinations
    clr();
    send(4'd2, 1'b1, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(4'd4, 1'b1, 5'd1, 5'd0, 5'd0, 32'd0);
    send(4'd15, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    cyc(2);
    chk("range_err", 32'(err), 32'd1);
    send(4'd2, 1'b1, 5'd1, 5'd0, 5'd0, 32'd2047);
    send(4'd2, 1'b1, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
    cyc(3);
`ifdef INST_ENC_NOP_FILL_EN
    nb = 3;
`else
    nb = 0;
`endif
    chk("range_n", 32'(cap.size()), 32'(nb + 2));
    if (cap.size() == nb + 2) begin
      chk("p2047_inst", cap[nb].inst, 32'h7FF00093);
      chk("p2047_addr", cap[nb].addr, 32'(4 * nb));
      chk("m2048_inst", cap[nb + 1].inst, 32'h80000093);
    end

    // backpressure: fifth request waits for space
    clr();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(4'd2, 1'b0, 5'(i + 1), 5'd1, 5'd2, 32'd0);
    req_alu = 4'd6; req_use_imm = 1'b0; req_rd = 5'd9;
    req_valid = 1'b1;
    cyc(2);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    send(4'd6, 1'b0, 5'd9, 5'd1, 5'd2, 32'd0);
    cyc(6);
    chk("drain_n", 32'(cap.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < cap.size()) chk("drain_addr", cap[i].addr, 32'(4 * i));

    // clear drops entries, err and a coincident request
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(4'd2, 1'b0, 5'd4, 5'd1, 5'd2, 32'd0);
    send(4'd15, 1'b1, 5'd4, 5'd1, 5'd2, 32'd0);
    req_valid = 1'b1;
    clr();
    req_valid = 1'b0;
    #3;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    cyc(1);
    out_ready = 1'b1;
    send(4'd2, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    cyc(2);
    chk("clr_n", 32'(cap.size()), 32'd1);
    if (cap.size() == 1) chk("clr_addr", cap[0].addr, BASE);

    // asynchronous reset in the middle of a drain
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(4'd5, 1'b0, 5'd4, 5'd1, 5'd2, 32'd0);
    out_ready = 1'b1;
    cyc(1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_inst", out_inst, 32'd0);
    chk("arst_addr", out_addr, BASE);
    chk("arst_ready", 32'(req_ready), 32'd1);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
